// File: rtl/pairing_host_if.sv
// pairing_host_if
// Host-side load/run/unload controller for the pairing core.
//   - Accepts a job on cmd_valid/cmd_ready and latches its function number.
//   - Streams N_IN operand words from s_valid/s_ready/s_data into the core's
//     external write port, one register stage deep.
//   - Pulses core_run for one cycle, then waits for core_endflag.
//   - Reads N_OUT result words from the core's external read port through a
//     credit-managed skid FIFO (depth RD_LAT+2) onto m_valid/m_ready/m_data,
//     flagging the last word with m_last and pulsing done once it is taken.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_func   job request
//   s_valid/s_ready/s_data         operand stream in
//   m_valid/m_ready/m_data/m_last  result stream out
//   done                           one-cycle end-of-job pulse
//   core_*                         pairing core control, write and read ports
module pairing_host_if #(
    parameter int DATA_W   = 304,
    parameter int ADDR_W   = 10,
    parameter int N_IN     = 24,
    parameter int N_OUT    = 12,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0,
    parameter int RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_func,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic              core_run,
    output logic [3:0]        core_n_func,
    output logic              core_extin_en,
    output logic [ADDR_W-1:0] core_extin_addr,
    output logic [DATA_W-1:0] core_extin_data,
    output logic [ADDR_W-1:0] core_extout_addr,
    input  logic [DATA_W-1:0] core_extout_data,
    input  logic              core_busy,
    input  logic              core_endflag
);

    localparam int CNT_MAX    = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
    localparam int USED_W     = OCC_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    load_cnt_reg, rd_cnt_reg, out_cnt_reg;
    logic [3:0]          func_reg;
    logic                extin_en_reg;
    logic [ADDR_W-1:0]   extin_addr_reg;
    logic [DATA_W-1:0]   extin_data_reg;
    logic                done_reg;
    logic [RD_LAT-1:0]   rd_pend_reg;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]    occ_reg;

    logic                cmd_hs, s_hs, issue, push, pop, last_out;
    logic [USED_W-1:0]   inflight, used;
    logic [RD_LAT:0]     pend_shift;

    // cmd_ready is forced low while rst is held so the host never sees a
    // ready during reset, even though the state register already reads IDLE.
    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign s_ready   = (state_reg == LOAD) && !core_busy;
    assign s_hs      = s_valid && s_ready;
    assign core_run  = (state_reg == START);

    // Reads still travelling through the core's read pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {{OCC_W{1'b0}}, rd_pend_reg[i]};
        end
    end

    // credits > 0  <=>  occupancy + in-flight < FIFO_DEPTH. A pop in the same
    // cycle is not credited, which still sustains one word per cycle.
    assign used       = {1'b0, occ_reg} + inflight;
    assign issue      = (state_reg == DRAIN) && !core_busy
                        && (rd_cnt_reg < CNT_W'(N_OUT))
                        && (used < USED_W'(FIFO_DEPTH));
    assign pend_shift = {rd_pend_reg, issue};
    assign push       = rd_pend_reg[RD_LAT-1];

    assign m_valid  = (state_reg == DRAIN) && (occ_reg != '0);
    assign pop      = m_valid && m_ready;
    assign last_out = (out_cnt_reg == CNT_W'(N_OUT - 1));
    assign m_last   = m_valid && last_out;
    assign m_data   = m_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign done     = done_reg;

    assign core_n_func      = func_reg;
    assign core_extin_en    = extin_en_reg;
    assign core_extin_addr  = extin_addr_reg;
    assign core_extin_data  = extin_data_reg;
    assign core_extout_addr = (state_reg == DRAIN)
                              ? ADDR_W'(OUT_BASE) + ADDR_W'(rd_cnt_reg) : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (cmd_hs) state_next = LOAD;
            LOAD:  if (s_hs && (load_cnt_reg == CNT_W'(N_IN - 1))) state_next = START;
            START: state_next = WAIT;
            WAIT:  if (core_endflag) state_next = DRAIN;
            DRAIN: if (pop && last_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            load_cnt_reg   <= '0;
            rd_cnt_reg     <= '0;
            out_cnt_reg    <= '0;
            func_reg       <= '0;
            extin_en_reg   <= 1'b0;
            extin_addr_reg <= '0;
            extin_data_reg <= '0;
            done_reg       <= 1'b0;
            rd_pend_reg    <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            extin_en_reg <= s_hs;
            done_reg     <= pop && last_out;
            rd_pend_reg  <= pend_shift[RD_LAT-1:0];

            if (s_hs) begin
                extin_addr_reg <= ADDR_W'(IN_BASE) + ADDR_W'(load_cnt_reg);
                extin_data_reg <= s_data;
                load_cnt_reg   <= load_cnt_reg + CNT_W'(1);
            end
            if (issue) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            if (pop)   out_cnt_reg <= out_cnt_reg + CNT_W'(1);

            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop)      occ_reg <= occ_reg + OCC_W'(1);
            else if (!push && pop) occ_reg <= occ_reg - OCC_W'(1);

            // A new job starts from a clean slate regardless of any residue.
            if (cmd_hs) begin
                func_reg     <= cmd_func;
                load_cnt_reg <= '0;
                rd_cnt_reg   <= '0;
                out_cnt_reg  <= '0;
                rd_pend_reg  <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                occ_reg      <= '0;
            end
        end
    end

    // FIFO storage carries no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= core_extout_data;
    end

endmodule

// File: tb/tb_pairing_host_if.sv
// Directed testbench for pairing_host_if. Plays the host on the cmd/s/m
// streams and a simple pairing core on the core_* port (RD_LAT=2 read pipe
// returning a fixed per-job result pattern).
module tb_pairing_host_if;

    localparam int DATA_W = 304;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              cmd_valid, cmd_ready;
    logic [3:0]        cmd_func;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid, m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last, done, core_run;
    logic [3:0]        core_n_func;
    logic              core_extin_en;
    logic [ADDR_W-1:0] core_extin_addr;
    logic [DATA_W-1:0] core_extin_data;
    logic [ADDR_W-1:0] core_extout_addr;
    logic [DATA_W-1:0] core_extout_data;
    logic              core_busy, core_endflag;

    int total = 0;
    int bad   = 0;
    int cur_job = 0;
    int run_cnt = 0;

    pairing_host_if dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .core_run(core_run), .core_n_func(core_n_func),
        .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
        .core_extin_data(core_extin_data), .core_extout_addr(core_extout_addr),
        .core_extout_data(core_extout_data), .core_busy(core_busy),
        .core_endflag(core_endflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] res_word(input int job, input int idx);
        logic [7:0] b;
        b = 8'(job * 16 + idx + 1);
        return {38{b}};
    endfunction

    function automatic logic [DATA_W-1:0] in_word(input int job, input int k);
        logic [DATA_W-1:0] w;
        w = '0;
        w[7:0] = 8'(k + 1);
        w[DATA_W-1:DATA_W-8] = 8'(job);
        return w;
    endfunction

    // Core read model: address registered twice, data valid RD_LAT cycles later.
    logic [ADDR_W-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= core_extout_addr;
        a2 <= a1;
    end
    assign core_extout_data = res_word(cur_job, int'(a2));

    always @(posedge clk) if (core_run) run_cnt <= run_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_cmd(input int job, input logic [3:0] func);
        cur_job   = job;
        cmd_valid = 1'b1;
        cmd_func  = func;
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("n_func", 32'(core_n_func), 32'(func));
        chk("cmd_ready_load", 32'(cmd_ready), 32'd0);
        $display("job %0d: cmd accepted func=%0d", job, func);
    endtask

    task automatic do_load(input int job, input int gap, input int busy_from, input int ef_at);
        int k = 0;
        int cyc = 0;
        int run_before;
        logic hs;
        run_before = run_cnt;
        while (k < 24 && cyc < 200) begin
            s_valid      = (gap != 0) ? ((cyc % 2) == 0) : 1'b1;
            core_busy    = (cyc >= busy_from) && (cyc < busy_from + 5);
            core_endflag = (cyc == ef_at);
            s_data       = in_word(job, k);
            #1;
            chk("s_ready", 32'(s_ready), 32'(!core_busy));
            hs = s_valid && !core_busy;
            tick();
            chk("extin_en", 32'(core_extin_en), 32'(hs));
            if (hs) begin
                chk("extin_addr", 32'(core_extin_addr), 32'(k));
                chkw("extin_data", core_extin_data, in_word(job, k));
                k++;
            end
            cyc++;
        end
        s_valid = 1'b0; core_busy = 1'b0; core_endflag = 1'b0;
        chk("load_count", 32'(k), 32'd24);
        chk("run_start", 32'(core_run), 32'd1);
        tick();
        chk("run_end", 32'(core_run), 32'd0);
        chk("run_pulses", 32'(run_cnt), 32'(run_before + 1));
        $display("job %0d: loaded %0d words in %0d cycles", job, k, cyc);
    endtask

    task automatic do_wait(input int hold_cmd);
        int run_before;
        run_before = run_cnt;
        cmd_valid  = (hold_cmd != 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("wait_run", 32'(core_run), 32'd0);
            chk("wait_mvalid", 32'(m_valid), 32'd0);
            tick();
        end
        cmd_valid    = 1'b0;
        core_endflag = 1'b1;
        tick();
        core_endflag = 1'b0;
        chk("wait_no_rerun", 32'(run_cnt), 32'(run_before));
        $display("wait done: endflag given");
    endtask

    task automatic do_drain(input int job, input int mode, input int stop_after, input int exp_cyc);
        int got = 0;
        int cyc = 0;
        while (got < stop_after && cyc < 400) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc < 20) ? 1'b0 : 1'($urandom_range(0, 1)));
            #1;
            if (mode == 1 && cyc == 19) begin
                chk("stall_addr", 32'(core_extout_addr), 32'd4);
                chk("stall_mvalid", 32'(m_valid), 32'd1);
            end
            if (m_valid && m_ready) begin
                chkw("m_data", m_data, res_word(job, got));
                chk("m_last", 32'(m_last), 32'(got == 11));
                chk("done_early", 32'(done), 32'd0);
                got++;
            end
            tick();
            cyc++;
        end
        chk("drain_words", 32'(got), 32'(stop_after));
        if (exp_cyc >= 0) chk("drain_cycles", 32'(cyc), 32'(exp_cyc));
        if (stop_after == 12) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("idle_ready", 32'(cmd_ready), 32'd1);
            m_ready = 1'b0;
            tick();
            chk("done_clear", 32'(done), 32'd0);
        end
        m_ready = 1'b0;
        $display("job %0d: drained %0d words in %0d cycles", job, got, cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chkw({tag, "_m_data"}, m_data, '0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_run"}, 32'(core_run), 32'd0);
        chk({tag, "_extin_en"}, 32'(core_extin_en), 32'd0);
        chk({tag, "_extout_addr"}, 32'(core_extout_addr), 32'd0);
        chk({tag, "_n_func"}, 32'(core_n_func), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_func = '0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b0; core_busy = 1'b0; core_endflag = 1'b0;
        #2;
        chk_all_zero("reset");
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_reset_ready", 32'(cmd_ready), 32'd1);
        $display("reset released");

        // Job 1: basic, stray endflag in IDLE and LOAD, cmd held in WAIT.
        core_endflag = 1'b1;
        #1;
        chk("idle_ef_ready", 32'(cmd_ready), 32'd1);
        tick();
        core_endflag = 1'b0;
        chk("idle_ef_stay", 32'(cmd_ready), 32'd1);
        chk("idle_ef_run", 32'(core_run), 32'd0);
        do_cmd(1, 4'd3);
        do_load(1, 0, -10, 5);
        do_wait(1);
        m_ready = 1'b1;
        chk("d0_mvalid", 32'(m_valid), 32'd0);
        chk("d0_addr", 32'(core_extout_addr), 32'd0);
        tick();
        chk("d1_mvalid", 32'(m_valid), 32'd0);
        chk("d1_addr", 32'(core_extout_addr), 32'd1);
        tick();
        chk("d2_mvalid", 32'(m_valid), 32'd0);
        tick();
        chk("d3_mvalid", 32'(m_valid), 32'd1);
        do_drain(1, 0, 12, 12);

        // Job 2: s_valid toggling.
        do_cmd(2, 4'd5);
        do_load(2, 1, -10, -1);
        do_wait(0);
        do_drain(2, 0, 12, 15);

        // Job 3: output back-pressure then random ready.
        do_cmd(3, 4'd7);
        do_load(3, 0, -10, -1);
        do_wait(0);
        do_drain(3, 1, 12, -1);

        // Job 4: core_busy for 5 cycles mid-load.
        do_cmd(4, 4'd9);
        do_load(4, 0, 6, -1);
        do_wait(0);
        do_drain(4, 0, 12, 15);

        // Job 5: reset after 5 words popped.
        do_cmd(5, 4'd2);
        do_load(5, 0, -10, -1);
        do_wait(0);
        do_drain(5, 0, 5, -1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);
        chk("rst_release_mvalid", 32'(m_valid), 32'd0);
        $display("mid-drain reset done");

        // Job 6: clean job after abort.
        do_cmd(6, 4'd4);
        do_load(6, 0, -10, -1);
        do_wait(0);
        do_drain(6, 0, 12, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pairing_host_if.md
# pairing_host_if

Host-side load/run/unload controller for the pairing core. It streams N_IN operand words from a valid/ready input into the core's external write port, starts the requested function, and waits for completion. It then streams N_OUT result words out of the core's external read port through a latency-tolerant skid FIFO onto a valid/ready output. It sits directly upstream and downstream of the pairing core, between that core and the host DMA/AXI-stream fabric.

## Interface
Parameters:
- DATA_W, 304: width of one redundant_poly_L3 word.
- ADDR_W, 10: core external address width (BRAM_DEPTH+1).
- N_IN, 24: words loaded per job.
- N_OUT, 12: words unloaded per job.
- IN_BASE, 0: first core write address.
- OUT_BASE, 0: first core read address.
- RD_LAT, 2: core read latency from extout_addr to extout_data, in cycles.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in/out  1  job request handshake.
- cmd_func  in  4  function number, latched on cmd handshake.
- s_valid / s_ready  in/out  1  operand stream handshake.
- s_data  in  DATA_W  operand word.
- m_valid / m_ready  out/in  1  result stream handshake.
- m_data  out  DATA_W  result word.
- m_last  out  1  high with the N_OUT-th result word.
- done  out  1  one-cycle pulse when the last result is accepted.
- core_run  out  1  start pulse to the core.
- core_n_func  out  4  function to the core.
- core_extin_en  out  1  core write enable.
- core_extin_addr  out  ADDR_W  core write address.
- core_extin_data  out  DATA_W  core write data.
- core_extout_addr  out  ADDR_W  core read address.
- core_extout_data  in  DATA_W  core read data.
- core_busy  in  1  core busy.
- core_endflag  in  1  core completion pulse.

## Operation
- FSM states: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE:
  - cmd_ready=1; all other handshake outputs are 0.
  - On cmd_valid: latch cmd_func into core_n_func, clear counters, go to LOAD.
- LOAD:
  - s_ready = ~core_busy.
  - Each s handshake registers core_extin_en=1, core_extin_addr=IN_BASE+load_cnt, core_extin_data=s_data; load_cnt increments.
  - After the N_IN-th handshake, go to START.
  - core_extin_en is 0 on every cycle without a handshake.
- START: core_run=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - core_run=0.
  - Stay until core_endflag=1 sampled, then go to DRAIN.
  - core_endflag is ignored in every other state.
- DRAIN, read issue:
  - core_extout_addr=OUT_BASE+rd_cnt.
  - A read is issued in a cycle when core_busy=0, rd_cnt<N_OUT, and credits>0.
  - credits = FIFO_DEPTH − occupancy − in-flight reads, with FIFO_DEPTH=RD_LAT+2.
  - A RD_LAT-deep valid shift register marks the returning reads; each returning word is pushed into the FIFO.
- DRAIN, output:
  - m_valid = FIFO non-empty; m_data is the FIFO head.
  - m_last=1 when out_cnt==N_OUT−1.
  - Pop on m_valid&m_ready.
  - After the last pop: done=1 for one cycle, go to IDLE.
- Arithmetic:
  - Counters are ceil(log2(max(N_IN,N_OUT)+1)) bits.
  - Address sums are truncated to ADDR_W; wrap past 2^ADDR_W is permitted and not flagged.
- cmd_valid seen outside IDLE is not accepted (cmd_ready=0) and is held by the host.

## Timing
- Reset values: every output is 0 (cmd_ready=0 while rst is asserted, and 1 in the first cycle after release), core_extout_addr=0, FIFO empty, state IDLE.
- rst mid-job: immediate abort to IDLE.
  - In-flight reads are discarded.
  - The core is not reset by this block.
- Write path: a s handshake in cycle t gives core_extin_en=1 in cycle t+1 (one register stage).
- START: core_run asserts the cycle after the final LOAD handshake.
- Read path:
  - A read issued in cycle t lands in the FIFO at the end of cycle t+RD_LAT.
  - m_valid rises at t+RD_LAT+1.
  - With m_ready held at 1, throughput is one word per cycle.
- Full back-pressure: credits reach 0 and issue stalls; no word is ever dropped or overwritten.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Job latency with no stalls, from cmd handshake to done: N_IN + 1 + core time + RD_LAT + N_OUT + 1 cycles.

## Test plan
- Basic job: cmd_func=3; 24 words 0x1…0x18 with s_valid always 1.
  - core_extin_addr 0..23 written with matching data, one run pulse.
  - After endflag, m_data = the model's 12 words, with m_last on the 12th and done the cycle after.
- Input gaps: s_valid toggling 1010….
  - core_extin_en is high only on handshake cycles; addresses stay contiguous 0..23.
- Output back-pressure: m_ready=0 for 20 cycles, then random.
  - Issue stalls after RD_LAT+2 outstanding words.
  - All 12 words arrive in order with no duplicates.
- core_busy glitch: core_busy=1 for 5 cycles during LOAD.
  - s_ready=0 throughout those 5 cycles; the load then resumes at the correct address.
- Reset mid-DRAIN: assert rst after 5 words popped.
  - All outputs go to 0 asynchronously; cmd_ready=1 the cycle after release; a new job runs cleanly.
- Stray signals: core_endflag pulsed in IDLE and LOAD, and cmd_valid held during WAIT.
  - No state change, no extra run pulse, cmd_ready=0 during WAIT.
